// File: rtl/ex_stage_pkg.sv
// Shared definitions for the GeMIPS execute stage: ALU op codes, load/store
// opcodes, EX/MEM memory-op encoding and the iterative multiplier states.
package ex_stage_pkg;

  localparam logic [7:0] ALU_OP_NOP = 8'h00;
  localparam logic [7:0] ALU_OP_ADD = 8'h01;
  localparam logic [7:0] ALU_OP_AND = 8'h02;
  localparam logic [7:0] ALU_OP_OR  = 8'h03;
  localparam logic [7:0] ALU_OP_XOR = 8'h04;
  localparam logic [7:0] ALU_OP_SLL = 8'h05;
  localparam logic [7:0] ALU_OP_SRL = 8'h06;
  localparam logic [7:0] ALU_OP_LUI = 8'h07;
  localparam logic [7:0] ALU_OP_JAR = 8'h08;
  localparam logic [7:0] ALU_OP_MUL = 8'h09;

  localparam logic [5:0] OPC_LW = 6'h23;
  localparam logic [5:0] OPC_LB = 6'h20;
  localparam logic [5:0] OPC_SW = 6'h2B;
  localparam logic [5:0] OPC_SB = 6'h28;

  typedef enum logic [2:0] {
    MEM_OP_NONE = 3'd0,
    MEM_OP_LW   = 3'd1,
    MEM_OP_LB   = 3'd2,
    MEM_OP_SW   = 3'd3,
    MEM_OP_SB   = 3'd4
  } mem_op_e;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_BUSY,
    MUL_DONE
  } mul_state_e;

  function automatic mem_op_e decode_mem_op(input logic [5:0] opc);
    case (opc)
      OPC_LW:  return MEM_OP_LW;
      OPC_LB:  return MEM_OP_LB;
      OPC_SW:  return MEM_OP_SW;
      OPC_SB:  return MEM_OP_SB;
      default: return MEM_OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_mul.sv
// Iterative multiplier: retires MUL_BITS multiplier bits per cycle and holds
// the finished product in DONE until the downstream stage accepts it.
module mul_iter
  import ex_stage_pkg::*;
#(
  parameter int unsigned MUL_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hold,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  localparam int unsigned N     = 32 / MUL_BITS;
  localparam int unsigned CNT_W = $clog2(N);

  mul_state_e       state, state_nx;
  logic [31:0]      mcand_q, mplier_q, acc;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      digit, step;

  assign digit   = 32'(mplier_q[MUL_BITS-1:0]);
  assign step    = (mcand_q * digit) << (32'(cnt) * MUL_BITS);
  assign done    = (state == MUL_DONE);
  assign product = acc;

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      MUL_IDLE: begin
        if (start) begin
          busy     = 1'b1;
          state_nx = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        busy = 1'b1;
        if (cnt == CNT_W'(N - 1)) state_nx = MUL_DONE;
      end
      MUL_DONE: begin
        if (!hold) state_nx = MUL_IDLE;
      end
      default: state_nx = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MUL_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      state <= state_nx;
      case (state)
        MUL_IDLE: begin
          if (start) begin
            mcand_q  <= mcand;
            mplier_q <= mplier;
            acc      <= '0;
            cnt      <= '0;
          end
        end
        MUL_BUSY: begin
          acc      <= acc + step;
          mplier_q <= mplier_q >> MUL_BITS;
          cnt      <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// GeMIPS execute stage: combinational ALU and address adder, forwarding bus
// back to decode, iterative MUL with front-end stall, and the EX/MEM register.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned MUL_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  waddr_i,
  input  logic        we_i,
  input  logic [31:0] link_addr_i,
  input  logic [31:0] inst_i,
  input  logic        stall_i,
  output logic        ex_we_o,
  output logic [4:0]  ex_waddr_o,
  output logic [31:0] ex_wdata_o,
  output logic        stallreq_o,
  output logic        mem_we_o,
  output logic [4:0]  mem_waddr_o,
  output logic [31:0] mem_wdata_o,
  output logic [2:0]  mem_op_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_sdata_o
);

  mem_op_e     mem_op;
  logic [31:0] result, mem_addr, mul_product;
  logic        mul_start, mul_busy, mul_done;
  logic        unused_inst;

  assign mem_op      = decode_mem_op(inst_i[31:26]);
  assign mem_addr    = reg1_i + {{16{inst_i[15]}}, inst_i[15:0]};
  assign unused_inst = ^inst_i[25:16];
  assign mul_start   = (aluop_i == ALU_OP_MUL) && !stall_i;

  mul_iter #(.MUL_BITS(MUL_BITS)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .hold    (stall_i),
    .mcand   (reg1_i),
    .mplier  (reg2_i),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    result = '0;
    case (aluop_i)
      ALU_OP_ADD: result = reg1_i + reg2_i;
      ALU_OP_AND: result = reg1_i & reg2_i;
      ALU_OP_OR:  result = reg1_i | reg2_i;
      ALU_OP_XOR: result = reg1_i ^ reg2_i;
      ALU_OP_SLL: result = reg1_i << reg2_i[4:0];
      ALU_OP_SRL: result = reg1_i >> reg2_i[4:0];
      ALU_OP_LUI: result = {reg2_i[15:0], 16'h0000};
      ALU_OP_JAR: result = link_addr_i;
      ALU_OP_MUL: result = mul_done ? mul_product : '0;
      default:    result = '0;
    endcase
    // Load data comes from MEM; nothing from EX is written back for loads.
    if (mem_op == MEM_OP_LW || mem_op == MEM_OP_LB) result = '0;
  end

  assign ex_we_o    = we_i;
  assign ex_waddr_o = waddr_i;
  assign ex_wdata_o = result;
  assign stallreq_o = mul_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we_o    <= 1'b0;
      mem_waddr_o <= '0;
      mem_wdata_o <= '0;
      mem_op_o    <= MEM_OP_NONE;
      mem_addr_o  <= '0;
      mem_sdata_o <= '0;
    end else if (!stall_i) begin
      if (stallreq_o) begin
        mem_we_o    <= 1'b0;
        mem_waddr_o <= '0;
        mem_wdata_o <= '0;
        mem_op_o    <= MEM_OP_NONE;
        mem_addr_o  <= '0;
        mem_sdata_o <= '0;
      end else begin
        mem_we_o    <= we_i;
        mem_waddr_o <= waddr_i;
        mem_wdata_o <= result;
        mem_op_o    <= mem_op;
        mem_addr_o  <= mem_addr;
        mem_sdata_o <= reg2_i;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver queues expected EX/MEM commits,
// a monitor pops and compares on every non-bubble EX/MEM load.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, we;
  logic [7:0]  aluop;
  logic [31:0] reg1, reg2, link_addr, inst;
  logic [4:0]  waddr;
  logic        ex_we_o, stallreq_o, mem_we_o;
  logic [4:0]  ex_waddr_o, mem_waddr_o;
  logic [31:0] ex_wdata_o, mem_wdata_o, mem_addr_o, mem_sdata_o;
  logic [2:0]  mem_op_o;

  logic [7:0]  d1_aluop;
  logic [31:0] d1_r1, d1_r2;
  logic        d1_we, d1_ex_we, d1_stallreq, d1_mem_we;
  logic [4:0]  d1_wa, d1_ex_waddr, d1_mem_waddr;
  logic [31:0] d1_ex_wdata, d1_mem_wdata, d1_mem_addr, d1_mem_sdata;
  logic [2:0]  d1_mem_op;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic loaded = 1'b0;

  always #5 clk = ~clk;

  ex_stage #(.MUL_BITS(4)) u_dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .reg1_i(reg1), .reg2_i(reg2),
    .waddr_i(waddr), .we_i(we), .link_addr_i(link_addr), .inst_i(inst),
    .stall_i(stall), .ex_we_o(ex_we_o), .ex_waddr_o(ex_waddr_o),
    .ex_wdata_o(ex_wdata_o), .stallreq_o(stallreq_o), .mem_we_o(mem_we_o),
    .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o), .mem_op_o(mem_op_o),
    .mem_addr_o(mem_addr_o), .mem_sdata_o(mem_sdata_o)
  );

  ex_stage #(.MUL_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .aluop_i(d1_aluop), .reg1_i(d1_r1), .reg2_i(d1_r2),
    .waddr_i(d1_wa), .we_i(d1_we), .link_addr_i(32'h0), .inst_i(32'h0),
    .stall_i(1'b0), .ex_we_o(d1_ex_we), .ex_waddr_o(d1_ex_waddr),
    .ex_wdata_o(d1_ex_wdata), .stallreq_o(d1_stallreq), .mem_we_o(d1_mem_we),
    .mem_waddr_o(d1_mem_waddr), .mem_wdata_o(d1_mem_wdata), .mem_op_o(d1_mem_op),
    .mem_addr_o(d1_mem_addr), .mem_sdata_o(d1_mem_sdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // EX/MEM monitor: any non-bubble load must match the oldest queued entry.
  always @(posedge clk) loaded <= !stall && !rst;

  always @(negedge clk) begin
    exp_t e;
    if (loaded && (mem_we_o || mem_op_o != 3'd0)) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected_commit: got wdata %h, required no commit", mem_wdata_o);
      end else begin
        e = sbq.pop_front();
        check("sb_we",    32'(mem_we_o),    32'(e.we));
        check("sb_waddr", 32'(mem_waddr_o), 32'(e.waddr));
        check("sb_wdata", mem_wdata_o,      e.wdata);
        check("sb_op",    32'(mem_op_o),    32'(e.op));
        check("sb_addr",  mem_addr_o,       e.addr);
        check("sb_sdata", mem_sdata_o,      e.sdata);
      end
    end
  end

  task automatic issue(input logic [7:0] op, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [4:0] wa, input logic w, input logic [31:0] link,
                       input logic [31:0] ins, input logic [31:0] exp_res,
                       input logic [2:0] exp_op, input logic [31:0] exp_addr,
                       input int exp_stalls, input int hold);
    exp_t e;
    int   stalls;
    @(negedge clk);
    aluop = op; reg1 = r1; reg2 = r2; waddr = wa; we = w; link_addr = link; inst = ins;
    e.we = w; e.waddr = wa; e.wdata = exp_res; e.op = exp_op; e.addr = exp_addr; e.sdata = r2;
    sbq.push_back(e);
    #1;
    check("fwd_we",    32'(ex_we_o),    32'(w));
    check("fwd_waddr", 32'(ex_waddr_o), 32'(wa));
    stalls = 0;
    while (stallreq_o && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
      check("bubble_we",    32'(mem_we_o), 32'h0);
      check("bubble_wdata", mem_wdata_o,   32'h0);
    end
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
    check("fwd_wdata", ex_wdata_o, exp_res);
    if (hold > 0) begin
      stall = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        #1;
        check("done_stallreq",  32'(stallreq_o), 32'h0);
        check("done_wdata",     ex_wdata_o,      exp_res);
        check("hold_mem_wdata", mem_wdata_o,     32'h0);
      end
      stall = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    rst = 1'b1; stall = 1'b0;
    aluop = ALU_OP_ADD; reg1 = 32'd5; reg2 = 32'd6; waddr = 5'd7; we = 1'b1;
    link_addr = '0; inst = '0;
    d1_aluop = ALU_OP_NOP; d1_r1 = '0; d1_r2 = '0; d1_we = 1'b0; d1_wa = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_we",    32'(mem_we_o),   32'h0);
    check("rst_mem_wdata", mem_wdata_o,     32'h0);
    check("rst_mem_waddr", 32'(mem_waddr_o), 32'h0);
    check("rst_stallreq",  32'(stallreq_o), 32'h0);
    check("rst_fwd_wdata", ex_wdata_o,      32'd11);
    rst = 1'b0; aluop = ALU_OP_NOP; we = 1'b0;

    //     op          r1            r2            wa     we    link          inst          result        op           addr          stalls hold
    issue(ALU_OP_ADD, 32'h7FFFFFFF, 32'h00000001, 5'd3,  1'b1, 32'h0,        32'h0,        32'h80000000, MEM_OP_NONE, 32'h7FFFFFFF, 0, 0);
    issue(ALU_OP_SLL, 32'h00000001, 32'd31,       5'd4,  1'b1, 32'h0,        32'h0,        32'h80000000, MEM_OP_NONE, 32'h00000001, 0, 0);
    issue(ALU_OP_SRL, 32'h80000000, 32'd4,        5'd5,  1'b1, 32'h0,        32'h0,        32'h08000000, MEM_OP_NONE, 32'h80000000, 0, 0);
    issue(ALU_OP_LUI, 32'h0,        32'h00001234, 5'd6,  1'b1, 32'h0,        32'h0,        32'h12340000, MEM_OP_NONE, 32'h0,        0, 0);
    issue(ALU_OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd7,  1'b1, 32'h0,        32'h0,        32'hF000F000, MEM_OP_NONE, 32'hF0F0F0F0, 0, 0);
    issue(ALU_OP_OR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd8,  1'b1, 32'h0,        32'h0,        32'hFFF0FFF0, MEM_OP_NONE, 32'hF0F0F0F0, 0, 0);
    issue(ALU_OP_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 5'd9,  1'b1, 32'h0,        32'h0,        32'h0FF00FF0, MEM_OP_NONE, 32'hF0F0F0F0, 0, 0);
    issue(8'hFF,      32'd5,        32'd7,        5'd10, 1'b1, 32'h0,        32'h0,        32'h0,        MEM_OP_NONE, 32'd5,        0, 0);
    issue(ALU_OP_MUL, 32'hFFFFFFFF, 32'd3,        5'd11, 1'b1, 32'h0,        32'h0,        32'hFFFFFFFD, MEM_OP_NONE, 32'hFFFFFFFF, 9, 0);
    issue(ALU_OP_ADD, 32'h00000100, 32'h55,       5'd2,  1'b1, 32'h0,        32'h8022FFFC, 32'h0,        MEM_OP_LB,   32'h000000FC, 0, 0);
    issue(ALU_OP_NOP, 32'h00000200, 32'hDEADBEEF, 5'd0,  1'b0, 32'h0,        32'hAC000008, 32'h0,        MEM_OP_SW,   32'h00000208, 0, 0);
    issue(ALU_OP_JAR, 32'h0,        32'h0,        5'd31, 1'b1, 32'h80000010, 32'h0C000000, 32'h80000010, MEM_OP_NONE, 32'h0,        0, 0);
    issue(ALU_OP_ADD, 32'h11,       32'h22,       5'd12, 1'b1, 32'h0,        32'h0,        32'h33,       MEM_OP_NONE, 32'h11,       0, 0);

    // Reset together with a downstream stall must still clear EX/MEM.
    @(negedge clk);
    rst = 1'b1; stall = 1'b1;
    @(negedge clk);
    #1;
    check("rst_stall_mem_we",    32'(mem_we_o), 32'h0);
    check("rst_stall_mem_wdata", mem_wdata_o,   32'h0);
    rst = 1'b0; stall = 1'b0; aluop = ALU_OP_NOP; we = 1'b0;

    // Reset in the middle of a multiply.
    @(negedge clk);
    aluop = ALU_OP_MUL; reg1 = 32'h12345678; reg2 = 32'd9; waddr = 5'd13; we = 1'b1; inst = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1; aluop = ALU_OP_NOP; we = 1'b0;
    @(negedge clk);
    #1;
    check("midmul_rst_stallreq",  32'(stallreq_o), 32'h0);
    check("midmul_rst_mem_we",    32'(mem_we_o),   32'h0);
    check("midmul_rst_mem_wdata", mem_wdata_o,     32'h0);
    rst = 1'b0;

    issue(ALU_OP_MUL, 32'd6,   32'd7,   5'd14, 1'b1, 32'h0, 32'h0, 32'd42,    MEM_OP_NONE, 32'd6,   9, 0);
    issue(ALU_OP_MUL, 32'd123, 32'd456, 5'd15, 1'b1, 32'h0, 32'h0, 32'd56088, MEM_OP_NONE, 32'd123, 9, 3);

    @(negedge clk);
    aluop = ALU_OP_NOP; we = 1'b0; inst = '0;
    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sbq.size()), 32'h0);

    // Single-bit multiplier instance.
    @(negedge clk);
    d1_aluop = ALU_OP_MUL; d1_r1 = 32'hFFFFFFFF; d1_r2 = 32'd3; d1_we = 1'b1; d1_wa = 5'd4;
    #1;
    s = 0;
    while (d1_stallreq && s < 100) begin
      s++;
      @(negedge clk);
      #1;
    end
    check("mb1_stall_cycles", 32'(s), 32'd33);
    check("mb1_fwd_wdata", d1_ex_wdata, 32'hFFFFFFFD);
    @(negedge clk);
    #1;
    check("mb1_mem_wdata", d1_mem_wdata, 32'hFFFFFFFD);
    check("mb1_mem_we", 32'(d1_mem_we), 32'h1);
    d1_aluop = ALU_OP_NOP; d1_we = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
